bcd_ascii_streamer: RTL

- Downstream stage of the double-dabble binary-to-BCD converter.
- Accepts one packed BCD word on a load pulse and streams it out as ASCII characters, most significant digit first, over a valid/ready handshake.
- Suppresses leading zeros; an all-zero value emits a single '0'.
- Feeds UART, debug-print and display formatting paths in the DFPU.

---
 rtl/bcd_ascii_streamer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/bcd_ascii_streamer.sv
// Streams a packed BCD word out as ASCII digits, most significant first, with leading-zero
// suppression. Define BCD_GROUP_SEP_EN to insert ',' between groups of three digits.
module bcd_ascii_streamer #(
    parameter int WID = 128,
    localparam int BCDWID = ((WID + (WID - 4) / 3) + 3) & -4,
    localparam int NDIG = BCDWID / 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic [BCDWID-1:0] bcd,
    output logic              busy,
    output logic [7:0]        char,
    output logic              char_vld,
    input  logic              char_rdy,
    output logic              last
);

    localparam int CW = $clog2(NDIG + 1);

`ifdef BCD_GROUP_SEP_EN
    typedef enum logic [1:0] {IDLE, SCAN, EMIT, SEP} state_t;
    // m tracks (dcnt-1) mod 3, i.e. how many lower digits remain after the current one
    localparam int M0 = (NDIG - 1) % 3;
    logic [1:0] m;
`else
    typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;
`endif

    state_t state;
    logic [BCDWID-1:0] sr;
    logic [CW-1:0]     dcnt;
    logic [3:0]        top;
    logic [3:0]        nxt;

    assign top = sr[BCDWID-1 -: 4];
    assign nxt = sr[BCDWID-5 -: 4];

    function automatic logic [7:0] ascii(input logic [3:0] d);
        return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            char_vld <= 1'b0;
            last     <= 1'b0;
            char     <= 8'h00;
            sr       <= '0;
            dcnt     <= '0;
`ifdef BCD_GROUP_SEP_EN
            m        <= 2'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ld) begin
                        sr    <= bcd;
                        dcnt  <= CW'(NDIG);
                        busy  <= 1'b1;
                        state <= SCAN;
`ifdef BCD_GROUP_SEP_EN
                        m     <= 2'(M0);
`endif
                    end
                end
                SCAN: begin
                    // only a genuine 0 digit is skipped; the final digit always prints
                    if (top == 4'd0 && dcnt > CW'(1)) begin
                        sr   <= sr << 4;
                        dcnt <= dcnt - CW'(1);
`ifdef BCD_GROUP_SEP_EN
                        m    <= (m == 2'd0) ? 2'd2 : m - 2'd1;
`endif
                    end else begin
                        char     <= ascii(top);
                        char_vld <= 1'b1;
                        last     <= (dcnt == CW'(1));
                        state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (char_rdy) begin
                        if (last) begin
                            char_vld <= 1'b0;
                            last     <= 1'b0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            sr   <= sr << 4;
                            dcnt <= dcnt - CW'(1);
`ifdef BCD_GROUP_SEP_EN
                            m    <= (m == 2'd0) ? 2'd2 : m - 2'd1;
                            if (m == 2'd0) begin
                                char  <= 8'h2C;
                                last  <= 1'b0;
                                state <= SEP;
                            end else begin
                                char <= ascii(nxt);
                                last <= (dcnt == CW'(2));
                            end
`else
                            char <= ascii(nxt);
                            last <= (dcnt == CW'(2));
`endif
                        end
                    end
                end
`ifdef BCD_GROUP_SEP_EN
                SEP: begin
                    // sr was already advanced when the preceding digit was taken
                    if (char_rdy) begin
                        char  <= ascii(top);
                        last  <= (dcnt == CW'(1));
                        state <= EMIT;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
